// File: rtl/ysyx_axi_sram.sv
// ysyx_axi_sram: AXI4 INCR-burst slave over a byte-writable 64-bit synchronous SRAM.
// One transaction outstanding; a write wins when AW and AR arrive together.
module ysyx_axi_sram #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int                IDX_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    input  logic [3:0]        s_arid,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [63:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic [3:0]        s_rid,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [3:0]        s_awid,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [63:0]       s_wdata,
    input  logic [7:0]        s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic [3:0]        s_bid,
    output logic              s_bvalid,
    input  logic              s_bready
);
    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t            state, state_nx;
    logic [63:0]       mem [0:(1<<IDX_W)-1];
    logic [63:0]       rdata_q;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [7:0]        len_q, cnt_q;
    logic [2:0]        size_q;
    logic [3:0]        id_q;
    logic              rerr_q, werr_q;
    logic              last, ar_hs, aw_hs, r_hs, w_hs, w_end, rd_en;
    logic [IDX_W-1:0]  rd_idx;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a - BASE} < ((ADDR_W+1)'(1) << (IDX_W + 3));
    endfunction

    assign last    = cnt_q == len_q;
    assign addr_nx = addr_q + (ADDR_W'(1) << size_q);
    assign ar_hs   = s_arvalid & s_arready;
    assign aw_hs   = s_awvalid & s_awready;
    assign r_hs    = s_rvalid & s_rready;
    assign w_hs    = s_wvalid & s_wready;
    assign w_end   = last | s_wlast;
    // The SRAM read is issued one cycle ahead so each beat's word is ready when rvalid shows it.
    assign rd_en   = ar_hs | (r_hs & !last);
    assign rd_idx  = state == IDLE ? s_araddr[IDX_W+2:3] : addr_nx[IDX_W+2:3];

    assign s_rdata = (state == RD && !rerr_q) ? rdata_q : 64'h0;
    assign s_rresp = {state == RD && rerr_q, 1'b0};
    assign s_rid   = id_q;
    assign s_rlast = state == RD && last;
    assign s_bresp = {state == WRESP && werr_q, 1'b0};
    assign s_bid   = id_q;

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx  = state;
        s_awready = 1'b0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        case (state)
            IDLE: begin
                s_awready = reset;
                s_arready = reset & !s_awvalid;
                state_nx  = s_awvalid ? WR : s_arvalid ? RD : IDLE;
            end
            RD: begin
                s_rvalid = 1'b1;
                state_nx = (s_rready && last) ? IDLE : RD;
            end
            WR: begin
                s_wready = 1'b1;
                state_nx = (s_wvalid && w_end) ? WRESP : WR;
            end
            WRESP: begin
                s_bvalid = 1'b1;
                state_nx = s_bready ? IDLE : WRESP;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            id_q   <= '0;
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
            cnt_q  <= '0;
            rerr_q <= 1'b0;
            werr_q <= 1'b0;
        end else if (aw_hs) begin
            id_q   <= s_awid;
            addr_q <= s_awaddr;
            len_q  <= s_awlen;
            size_q <= s_awsize;
            cnt_q  <= '0;
            werr_q <= 1'b0;
        end else if (ar_hs) begin
            id_q   <= s_arid;
            addr_q <= s_araddr;
            len_q  <= s_arlen;
            size_q <= s_arsize;
            cnt_q  <= '0;
            rerr_q <= !in_range(s_araddr);
        end else if (r_hs | w_hs) begin
            addr_q <= addr_nx;
            cnt_q  <= cnt_q + 8'd1;
            rerr_q <= !in_range(addr_nx);
            // Sticky write error: any out-of-range beat, or wlast disagreeing with the beat count.
            werr_q <= werr_q | (w_hs & (!in_range(addr_q) | (w_end & (last != s_wlast))));
        end

    always_ff @(posedge clock) begin
        if (w_hs && in_range(addr_q))
            for (int i = 0; i < 8; i++)
                if (s_wstrb[i]) mem[addr_q[IDX_W+2:3]][i*8 +: 8] <= s_wdata[i*8 +: 8];
        if (rd_en) rdata_q <= mem[rd_idx];
    end
endmodule
